// File: rtl/control_unit.sv
// Multicycle LEGv8 instruction controller: opcode decode, immediate extraction and FETCH/EXECUTE/WRITEBACK sequencing.
// Optional macro CTRL_FLAG_SET_EN makes ADD/ADDI/SUB/SUBI load the status flags in EXECUTE.
module control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    output logic [63:0] constant,
    output logic [35:0] control_word
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        EXECUTE   = 2'd1,
        WRITEBACK = 2'd2,
        UNUSED_ST = 2'd3
    } state_t;

    localparam int SEL_ADD  = 0,  SEL_ADDI = 1,  SEL_SUB  = 2,  SEL_SUBI = 3;
    localparam int SEL_AND  = 4,  SEL_ANDI = 5,  SEL_ORR  = 6,  SEL_ORRI = 7;
    localparam int SEL_EOR  = 8,  SEL_EORI = 9,  SEL_LSL  = 10, SEL_LSR  = 11;
    localparam int SEL_LDUR = 12, SEL_STUR = 13, SEL_B    = 14, SEL_CBZ  = 15;
    localparam int SEL_CBNZ = 16;

    localparam logic [4:0] FS_AND = 5'b00000, FS_ORR = 5'b00100, FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001, FS_EOR = 5'b01100, FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100, FS_PASS_B = 5'b11000;

    state_t      state, next_state;
    logic [16:0] select;
    logic        r_alu, i_alu, shift, d_type, cb;
    logic [4:0]  alu_fs, fs, da, sa, sb;
    logic        reg_write, ram_write, b_sel, status_load;
    logic        en_alu, en_ram, en_pc, ir_load, pc_load, c_in;
    logic [1:0]  pc_sel;
    logic        unused_flags;

    // Only the live zero bit steers branching; stored flags belong to the datapath.
    assign unused_flags = ^status[3:0];

    always_comb begin
        select = '0;
        if (instruction[31:21] == 11'b10001011000) select[SEL_ADD]  = 1'b1;
        if (instruction[31:22] == 10'b1001000100)  select[SEL_ADDI] = 1'b1;
        if (instruction[31:21] == 11'b11001011000) select[SEL_SUB]  = 1'b1;
        if (instruction[31:22] == 10'b1101000100)  select[SEL_SUBI] = 1'b1;
        if (instruction[31:21] == 11'b10001010000) select[SEL_AND]  = 1'b1;
        if (instruction[31:22] == 10'b1001001000)  select[SEL_ANDI] = 1'b1;
        if (instruction[31:21] == 11'b10101010000) select[SEL_ORR]  = 1'b1;
        if (instruction[31:22] == 10'b1011001000)  select[SEL_ORRI] = 1'b1;
        if (instruction[31:21] == 11'b11001010000) select[SEL_EOR]  = 1'b1;
        if (instruction[31:22] == 10'b1101001000)  select[SEL_EORI] = 1'b1;
        if (instruction[31:21] == 11'b11010011011) select[SEL_LSL]  = 1'b1;
        if (instruction[31:21] == 11'b11010011010) select[SEL_LSR]  = 1'b1;
        if (instruction[31:21] == 11'b11111000010) select[SEL_LDUR] = 1'b1;
        if (instruction[31:21] == 11'b11111000000) select[SEL_STUR] = 1'b1;
        if (instruction[31:26] == 6'b000101)       select[SEL_B]    = 1'b1;
        if (instruction[31:24] == 8'b10110100)     select[SEL_CBZ]  = 1'b1;
        if (instruction[31:24] == 8'b10110101)     select[SEL_CBNZ] = 1'b1;
    end

    assign r_alu  = select[SEL_ADD] | select[SEL_SUB] | select[SEL_AND] | select[SEL_ORR] | select[SEL_EOR];
    assign i_alu  = select[SEL_ADDI] | select[SEL_SUBI] | select[SEL_ANDI] | select[SEL_ORRI] | select[SEL_EORI];
    assign shift  = select[SEL_LSL] | select[SEL_LSR];
    assign d_type = select[SEL_LDUR] | select[SEL_STUR];
    assign cb     = select[SEL_CBZ] | select[SEL_CBNZ];

    always_comb begin
        constant = '0;
        if (i_alu)              constant = {52'd0, instruction[21:10]};
        else if (d_type)        constant = {{55{instruction[20]}}, instruction[20:12]};
        else if (shift)         constant = {58'd0, instruction[15:10]};
        else if (select[SEL_B]) constant = {{36{instruction[25]}}, instruction[25:0], 2'b00};
        else if (cb)            constant = {{43{instruction[23]}}, instruction[23:5], 2'b00};
    end

    always_comb begin
        alu_fs = FS_AND;
        if (select[SEL_ADD] | select[SEL_ADDI] | d_type)  alu_fs = FS_ADD;
        else if (select[SEL_SUB] | select[SEL_SUBI])      alu_fs = FS_SUB;
        else if (select[SEL_ORR] | select[SEL_ORRI])      alu_fs = FS_ORR;
        else if (select[SEL_EOR] | select[SEL_EORI])      alu_fs = FS_EOR;
        else if (select[SEL_LSL])                         alu_fs = FS_LSL;
        else if (select[SEL_LSR])                         alu_fs = FS_LSR;
        else if (cb)                                      alu_fs = FS_PASS_B;
    end

    always_comb begin
        case (state)
            FETCH:   next_state = EXECUTE;
            EXECUTE: next_state = select[SEL_LDUR] ? WRITEBACK : FETCH;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        fs = '0; da = '0; sa = '0; sb = '0;
        reg_write = 1'b0; ram_write = 1'b0; b_sel = 1'b0; status_load = 1'b0;
        en_alu = 1'b0; en_ram = 1'b0; en_pc = 1'b0; ir_load = 1'b0;
        pc_load = 1'b0; c_in = 1'b0; pc_sel = 2'b00;
        case (state)
            FETCH: ir_load = 1'b1;
            EXECUTE: begin
                pc_load = 1'b1;
                da      = instruction[4:0];
                sa      = instruction[9:5];
                fs      = alu_fs;
                c_in    = select[SEL_SUB] | select[SEL_SUBI];
                if (r_alu | shift)            sb = instruction[20:16];
                if (select[SEL_STUR] | cb)    sb = instruction[4:0];
                if (r_alu | i_alu | shift) begin
                    en_alu    = 1'b1;
                    reg_write = 1'b1;
                    b_sel     = i_alu | shift;
                end
                if (select[SEL_LDUR]) begin
                    b_sel  = 1'b1;
                    en_alu = 1'b1;
                end
                if (select[SEL_STUR]) begin
                    b_sel     = 1'b1;
                    ram_write = 1'b1;
                end
                if (select[SEL_B]) pc_sel = 2'b01;
                if (cb) en_alu = 1'b1;
                // Zero flag comes live from the ALU passing register B through.
                if ((select[SEL_CBZ] & status[4]) | (select[SEL_CBNZ] & ~status[4])) pc_sel = 2'b01;
`ifdef CTRL_FLAG_SET_EN
                status_load = select[SEL_ADD] | select[SEL_ADDI] | select[SEL_SUB] | select[SEL_SUBI];
`else
                status_load = 1'b0;
`endif
            end
            WRITEBACK: begin
                da        = instruction[4:0];
                sa        = instruction[9:5];
                en_ram    = 1'b1;
                reg_write = 1'b1;
            end
            default: ;
        endcase
        control_word = '0;
        if (reset) begin
            control_word = {state, next_state, c_in, pc_load, ir_load, pc_sel, en_pc, en_ram,
                            en_alu, status_load, b_sel, ram_write, reg_write, sb, sa, da, fs};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode, immediates, state sequencing and control word fields.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = '0;
    logic [4:0]  status = '0;
    logic [63:0] constant;
    logic [35:0] control_word;

    int checks = 0;
    int failures = 0;

`ifdef CTRL_FLAG_SET_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    control_unit dut (
        .clock(clock),
        .reset(reset),
        .instruction(instruction),
        .status(status),
        .constant(constant),
        .control_word(control_word)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        instruction = 32'h91000422;
        tick();
        tick();
        checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", dut.state); end
        checks++; if (control_word !== 36'h0) begin failures++; $display("FAIL reset_cw: got %h want 0", control_word); end
        checks++; if (constant !== 64'd1) begin failures++; $display("FAIL reset_const: got %h want 1", constant); end
        reset = 1'b1;
        #1;
        checks++; if (control_word !== 36'h120000000) begin failures++; $display("FAIL fetch_cw: got %h want 120000000", control_word); end
        tick();
        checks++; if (dut.state !== 2'd1) begin failures++; $display("FAIL release_exec: got %0d want 1", dut.state); end
        tick();
        checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL release_fetch: got %0d want 0", dut.state); end
    endtask

    task automatic test_lsl;
        instruction = 32'hD36B839C;
        #1;
        checks++; if (dut.select !== 17'h00400) begin failures++; $display("FAIL lsl_select: got %h want 00400", dut.select); end
        checks++; if (constant !== 64'd32) begin failures++; $display("FAIL lsl_const: got %0d want 32", constant); end
        tick();
        checks++; if (control_word[4:0] !== 5'b10000) begin failures++; $display("FAIL lsl_fs: got %b want 10000", control_word[4:0]); end
        checks++; if (control_word[9:5] !== 5'd28) begin failures++; $display("FAIL lsl_da: got %0d want 28", control_word[9:5]); end
        checks++; if (control_word[14:10] !== 5'd28) begin failures++; $display("FAIL lsl_sa: got %0d want 28", control_word[14:10]); end
        checks++; if ({control_word[30], control_word[22], control_word[20]} !== 3'b111) begin
            failures++; $display("FAIL lsl_pcload_bsel_regwr: got %b want 111", {control_word[30], control_word[22], control_word[20]}); end
        checks++; if (control_word[35:32] !== 4'b0100) begin failures++; $display("FAIL lsl_states: got %b want 0100", control_word[35:32]); end
        tick();
    endtask

    task automatic test_addi;
        logic [35:0] exp_cw;
        instruction = 32'h91000422;
        #1;
        checks++; if (dut.select !== 17'h00002) begin failures++; $display("FAIL addi_select: got %h want 00002", dut.select); end
        checks++; if (constant !== 64'd1) begin failures++; $display("FAIL addi_const: got %0d want 1", constant); end
        tick();
        exp_cw = 36'h441500448 | (FLAG_EN ? 36'h000800000 : 36'h0);
        checks++; if (control_word !== exp_cw) begin failures++; $display("FAIL addi_cw: got %h want %h", control_word, exp_cw); end
        tick();
    endtask

    task automatic test_cbz;
        instruction = 32'hB4000030;
        status = 5'h10;
        #1;
        checks++; if (dut.select !== 17'h08000) begin failures++; $display("FAIL cbz_select: got %h want 08000", dut.select); end
        checks++; if (constant !== 64'd4) begin failures++; $display("FAIL cbz_const: got %0d want 4", constant); end
        tick();
        checks++; if (control_word[19:15] !== 5'd16) begin failures++; $display("FAIL cbz_sb: got %0d want 16", control_word[19:15]); end
        checks++; if (control_word[4:0] !== 5'b11000) begin failures++; $display("FAIL cbz_fs: got %b want 11000", control_word[4:0]); end
        checks++; if (control_word[28:27] !== 2'b01) begin failures++; $display("FAIL cbz_taken: got %b want 01", control_word[28:27]); end
        status = 5'h00;
        #1;
        checks++; if (control_word[28:27] !== 2'b00) begin failures++; $display("FAIL cbz_not_taken: got %b want 00", control_word[28:27]); end
        tick();
    endtask

    task automatic test_ldur;
        instruction = 32'hF84083E1;
        status = 5'h0;
        #1;
        checks++; if (constant !== 64'd8) begin failures++; $display("FAIL ldur_const: got %0d want 8", constant); end
        checks++; if (dut.select !== 17'h01000) begin failures++; $display("FAIL ldur_select: got %h want 01000", dut.select); end
        tick();
        checks++; if (control_word[35:32] !== 4'b0110) begin failures++; $display("FAIL ldur_exec_states: got %b want 0110", control_word[35:32]); end
        checks++; if ({control_word[24], control_word[22], control_word[4:0]} !== 7'b1101000) begin
            failures++; $display("FAIL ldur_exec_addr: got %b want 1101000", {control_word[24], control_word[22], control_word[4:0]}); end
        tick();
        checks++; if (dut.state !== 2'd2) begin failures++; $display("FAIL ldur_wb_state: got %0d want 2", dut.state); end
        checks++; if ({control_word[25], control_word[20], control_word[30], control_word[21]} !== 4'b1100) begin
            failures++; $display("FAIL ldur_wb_ctrl: got %b want 1100", {control_word[25], control_word[20], control_word[30], control_word[21]}); end
        checks++; if (control_word[33:32] !== 2'd0) begin failures++; $display("FAIL ldur_wb_next: got %0d want 0", control_word[33:32]); end
        tick();
        checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL ldur_return: got %0d want 0", dut.state); end
    endtask

    task automatic test_nop;
        instruction = 32'h00000000;
        #1;
        checks++; if (dut.select !== 17'h0) begin failures++; $display("FAIL nop_select: got %h want 0", dut.select); end
        checks++; if (constant !== 64'd0) begin failures++; $display("FAIL nop_const: got %h want 0", constant); end
        tick();
        checks++; if (control_word !== 36'h440000000) begin failures++; $display("FAIL nop_cw: got %h want 440000000", control_word); end
        tick();
    endtask

    task automatic test_sign_ext;
        instruction = 32'h17FFFFFF;
        #1;
        checks++; if (constant !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL b_const: got %h want fffffffffffffffc", constant); end
        tick();
        checks++; if ({control_word[28:27], control_word[20]} !== 3'b010) begin
            failures++; $display("FAIL b_pcsel: got %b want 010", {control_word[28:27], control_word[20]}); end
        tick();
        instruction = 32'hB5FFFFE0;
        status = 5'h00;
        #1;
        checks++; if (constant !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL cbnz_const: got %h want fffffffffffffffc", constant); end
        tick();
        checks++; if (control_word[28:27] !== 2'b01) begin failures++; $display("FAIL cbnz_taken: got %b want 01", control_word[28:27]); end
        status = 5'h10;
        #1;
        checks++; if (control_word[28:27] !== 2'b00) begin failures++; $display("FAIL cbnz_not_taken: got %b want 00", control_word[28:27]); end
        tick();
        status = 5'h00;
        instruction = 32'hF81F03E0;
        #1;
        checks++; if (constant !== 64'hFFFF_FFFF_FFFF_FFF0) begin failures++; $display("FAIL stur_const: got %h want fffffffffffffff0", constant); end
        tick();
        checks++; if ({control_word[21], control_word[20], control_word[4:0]} !== 7'b1001000) begin
            failures++; $display("FAIL stur_ctrl: got %b want 1001000", {control_word[21], control_word[20], control_word[4:0]}); end
        tick();
    endtask

    task automatic test_sub_flags;
        instruction = 32'hCB020020;
        #1;
        tick();
        checks++; if ({control_word[31], control_word[4:0]} !== 6'b101001) begin
            failures++; $display("FAIL sub_cin_fs: got %b want 101001", {control_word[31], control_word[4:0]}); end
        checks++; if (control_word[19:15] !== 5'd2) begin failures++; $display("FAIL sub_sb: got %0d want 2", control_word[19:15]); end
        checks++; if (control_word[23] !== FLAG_EN) begin failures++; $display("FAIL sub_status_load: got %b want %b", control_word[23], FLAG_EN); end
        tick();
    endtask

    task automatic test_mid_change;
        instruction = 32'h91000422;
        #1;
        tick();
        instruction = 32'hF84083E1;
        #1;
        checks++; if ({control_word[33:32], control_word[20]} !== 3'b100) begin
            failures++; $display("FAIL midchg_follow: got %b want 100", {control_word[33:32], control_word[20]}); end
        tick();
        checks++; if (dut.state !== 2'd2) begin failures++; $display("FAIL midchg_wb: got %0d want 2", dut.state); end
        tick();
    endtask

    task automatic test_reset_mid;
        instruction = 32'hF84083E1;
        #1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (control_word !== 36'h0) begin failures++; $display("FAIL rstmid_cw: got %h want 0", control_word); end
        tick();
        checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL rstmid_state: got %0d want 0", dut.state); end
        reset = 1'b1;
        #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] prog [4];
        int          len  [4];
        prog[0] = 32'h8B020020; len[0] = 2;
        prog[1] = 32'hF84083E1; len[1] = 3;
        prog[2] = 32'h00000000; len[2] = 2;
        prog[3] = 32'hF84083E1; len[3] = 3;
        for (int i = 0; i < 4; i++) begin
            instruction = prog[i];
            #1;
            for (int c = 0; c < len[i]; c++) begin
                checks++; if (dut.state !== 2'(c)) begin
                    failures++; $display("FAIL b2b_state[%0d.%0d]: got %0d want %0d", i, c, dut.state, c); end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_addi();
        test_cbz();
        test_ldur();
        test_nop();
        test_sign_ext();
        test_sub_flags();
        test_mid_change();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
